// File: rtl/sr_pkg.sv
// Shared definitions for the SR flip-flop command driver.
// Op encoding, FSM state type and the pulse/gap counter width.
package sr_pkg;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    GAP    = 2'd3
  } state_t;

endpackage

// File: rtl/sr_cmd_fifo.sv
// Synchronous 1-bit command FIFO.
// Pointers carry one extra MSB so that full and empty can be told apart.
module sr_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        din,
  output logic        dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  logic [DEPTH-1:0] mem;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sr_cmd_driver.sv
// Turns queued set/reset commands into non-overlapping S/R pulses and
// checks the flip-flop's Q after each pulse.
//
//   state  | meaning
//   IDLE   | waiting for a queued command; pops the head when present
//   PULSE  | driving S (set) or R (reset) for PULSE_W cycles
//   SETTLE | one quiet cycle, then Q is compared against the issued op
//   GAP    | GAP_W cycles of forced S=R=0 before the next command
module sr_cmd_driver
  import sr_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_op,
  input  logic                     q_in,
  output logic                     S,
  output logic                     R,
  output logic                     busy,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   level
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               op, op_nxt;
  logic               err_nxt;
  logic               push, pop;
  logic               fifo_dout, fifo_full, fifo_empty;

  assign cmd_ready = !fifo_full && !rst;
  assign push      = cmd_valid && cmd_ready;

  sr_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (cmd_op),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= OP_RESET;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op    <= op_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op;
    err_nxt   = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          op_nxt    = fifo_dout;
          cnt_nxt   = CNT_W'(PULSE_W - 1);
          state_nxt = PULSE;
        end
      end
      PULSE: begin
        if (cnt == '0) state_nxt = SETTLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      SETTLE: begin
        // Q has had one quiet cycle to resolve; a redundant command still checks.
        err_nxt   = (q_in != op);
        cnt_nxt   = CNT_W'(GAP_W - 1);
        state_nxt = GAP;
      end
      GAP: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded from registered state and op only, so S and R can never overlap.
  assign S    = (state == PULSE) && (op == OP_SET);
  assign R    = (state == PULSE) && (op == OP_RESET);
  assign busy = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed bench for sr_cmd_driver with a behavioural SR flip-flop on S/R/q_in.
module tb_sr_cmd_driver;

  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_op = 1'b0;
  logic          q_in;
  logic          cmd_ready, S, R, busy, err;
  logic [LW-1:0] level;

  sr_cmd_driver #(
    .PULSE_W (2),
    .GAP_W   (1),
    .DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .q_in      (q_in),
    .S         (S),
    .R         (R),
    .busy      (busy),
    .err       (err),
    .level     (level)
  );

  always #5 clk = ~clk;

  logic q_ff = 1'b0;
  bit   force_q0 = 1'b0;
  assign q_in = force_q0 ? 1'b0 : q_ff;

  always @(posedge clk) begin
    if (S === 1'b1)      q_ff <= 1'b1;
    else if (R === 1'b1) q_ff <= 1'b0;
  end

  int   vectors = 0;
  int   miscompares = 0;
  int   err_cnt = 0;
  bit   mon_on = 1'b0;
  logic prev_pulse = 1'b0;
  logic exp_q[$];
  logic iss_q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample #1 after the edge; tracks issued ops and err pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mon_on) begin
      chk("s_and_r_exclusive", {7'd0, S && R}, 8'd0);
      if ((S || R) && !prev_pulse) iss_q.push_back(S);
      prev_pulse = S || R;
      if (err === 1'b1) err_cnt++;
    end
  endtask

  task automatic push_cmd(input logic op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, {7'd0, busy}, 8'd0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_S", {7'd0, S}, 8'd0);
    chk("rst_R", {7'd0, R}, 8'd0);
    chk("rst_err", {7'd0, err}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_level", {5'd0, level}, 8'd0);
    chk("rst_ready", {7'd0, cmd_ready}, 8'd0);
    mon_on = 1'b1;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {7'd0, cmd_ready}, 8'd1);

    // single set
    push_cmd(1'b1); exp_q.push_back(1'b1);
    chk("t1_level_e0", {5'd0, level}, 8'd1);
    chk("t1_busy_e0", {7'd0, busy}, 8'd1);
    chk("t1_S_e0", {7'd0, S}, 8'd0);
    tick();
    chk("t1_S_e1", {7'd0, S}, 8'd1);
    chk("t1_R_e1", {7'd0, R}, 8'd0);
    chk("t1_level_e1", {5'd0, level}, 8'd0);
    tick();
    chk("t1_S_e2", {7'd0, S}, 8'd1);
    tick();
    chk("t1_S_e3", {7'd0, S}, 8'd0);
    chk("t1_q_e3", {7'd0, q_in}, 8'd1);
    tick();
    chk("t1_err_e4", {7'd0, err}, 8'd0);
    chk("t1_busy_e4", {7'd0, busy}, 8'd1);
    tick();
    chk("t1_busy_e5", {7'd0, busy}, 8'd0);

    // set then reset back-to-back; second push lands on the pop edge
    push_cmd(1'b1); exp_q.push_back(1'b1);
    push_cmd(1'b0); exp_q.push_back(1'b0);
    chk("t2_pushpop_level", {5'd0, level}, 8'd1);
    chk("t2_S_e1", {7'd0, S}, 8'd1);
    tick();
    chk("t2_S_e2", {7'd0, S}, 8'd1);
    tick();
    chk("t2_S_e3", {7'd0, S}, 8'd0);
    tick();
    tick();
    chk("t2_R_e5", {7'd0, R}, 8'd0);
    tick();
    chk("t2_R_e6", {7'd0, R}, 8'd1);
    chk("t2_S_e6", {7'd0, S}, 8'd0);
    chk("t2_level_e6", {5'd0, level}, 8'd0);
    tick();
    chk("t2_R_e7", {7'd0, R}, 8'd1);
    tick();
    chk("t2_R_e8", {7'd0, R}, 8'd0);
    chk("t2_q_e8", {7'd0, q_in}, 8'd0);
    tick();
    chk("t2_err_e9", {7'd0, err}, 8'd0);
    tick();
    chk("t2_busy_e10", {7'd0, busy}, 8'd0);

    // fill with cmd_valid held
    cmd_valid = 1'b1;
    cmd_op = 1'b1; tick(); exp_q.push_back(1'b1);
    chk("t3_level_e0", {5'd0, level}, 8'd1);
    cmd_op = 1'b0; tick(); exp_q.push_back(1'b0);
    chk("t3_level_e1", {5'd0, level}, 8'd1);
    cmd_op = 1'b1; tick(); exp_q.push_back(1'b1);
    chk("t3_level_e2", {5'd0, level}, 8'd2);
    cmd_op = 1'b1; tick(); exp_q.push_back(1'b1);
    chk("t3_level_e3", {5'd0, level}, 8'd3);
    cmd_op = 1'b0; tick(); exp_q.push_back(1'b0);
    chk("t3_level_e4", {5'd0, level}, 8'd4);
    chk("t3_ready_e4", {7'd0, cmd_ready}, 8'd0);
    cmd_op = 1'b1; tick();
    chk("t3_level_e5", {5'd0, level}, 8'd4);
    chk("t3_ready_e5", {7'd0, cmd_ready}, 8'd0);
    tick();
    chk("t3_level_e6", {5'd0, level}, 8'd3);
    chk("t3_ready_e6", {7'd0, cmd_ready}, 8'd1);
    tick(); exp_q.push_back(1'b1);
    chk("t3_level_e7", {5'd0, level}, 8'd4);
    chk("t3_ready_e7", {7'd0, cmd_ready}, 8'd0);
    cmd_valid = 1'b0;
    wait_idle("t3_drain");

    // readback failure with Q stuck low
    force_q0 = 1'b1;
    push_cmd(1'b1); exp_q.push_back(1'b1);
    tick(); tick(); tick();
    chk("t4_err_e3", {7'd0, err}, 8'd0);
    tick();
    chk("t4_err_e4", {7'd0, err}, 8'd1);
    tick();
    chk("t4_err_e5", {7'd0, err}, 8'd0);
    chk("t4_busy_e5", {7'd0, busy}, 8'd0);
    force_q0 = 1'b0;
    push_cmd(1'b0); exp_q.push_back(1'b0);
    tick(); tick(); tick(); tick();
    chk("t4_err_next", {7'd0, err}, 8'd0);
    wait_idle("t4_idle");
    chk("t4_q_final", {7'd0, q_in}, 8'd0);

    // reset mid-pulse flushes the queued reset command
    push_cmd(1'b1); exp_q.push_back(1'b1);
    push_cmd(1'b0);
    chk("t5_S_e1", {7'd0, S}, 8'd1);
    tick();
    chk("t5_S_e2", {7'd0, S}, 8'd1);
    rst = 1'b1;
    #1;
    chk("t5_ready_rst", {7'd0, cmd_ready}, 8'd0);
    tick();
    chk("t5_S_e3", {7'd0, S}, 8'd0);
    chk("t5_R_e3", {7'd0, R}, 8'd0);
    chk("t5_level_e3", {5'd0, level}, 8'd0);
    chk("t5_busy_e3", {7'd0, busy}, 8'd0);
    chk("t5_err_e3", {7'd0, err}, 8'd0);
    tick();
    chk("t5_err_e4", {7'd0, err}, 8'd0);
    rst = 1'b0;
    push_cmd(1'b0); exp_q.push_back(1'b0);
    tick();
    chk("t5_R_resume", {7'd0, R}, 8'd1);
    wait_idle("t5_idle");
    chk("t5_q_final", {7'd0, q_in}, 8'd0);

    chk("issued_count", 8'(iss_q.size()), 8'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < iss_q.size()) chk($sformatf("issued_op_%0d", i), {7'd0, iss_q[i]}, {7'd0, exp_q[i]});
    end
    chk("err_pulse_total", 8'(err_cnt), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
